// File: rtl/udp_fifo_pkt_reader_pkg.sv
// Shared types and constants for the UDP loopback FIFO packet reader.
package udp_fifo_pkg;

    localparam int c_SKID_DEPTH = 2;
    localparam int c_SKID_CNT_W = $clog2(c_SKID_DEPTH + 1);
    localparam int c_LEN_WIDTH  = 16;

    typedef logic [c_LEN_WIDTH-1:0] len_t;

    typedef enum logic [1:0] {
        ST_IDLE     = 2'd0,
        ST_ANNOUNCE = 2'd1,
        ST_STREAM   = 2'd2,
        ST_SETTLE   = 2'd3
    } rd_state_t;

endpackage

// File: rtl/udp_fifo_pkt_reader_skid2.sv
// Two-entry skid buffer that absorbs the FIFO's one-cycle read latency
// so the outgoing byte stream can run back-to-back.
module udp_fifo_skid2
    import udp_fifo_pkg::*;
#(
    parameter int c_DATA_WIDTH = 8
)
(
    input  logic                    i_clk,
    input  logic                    i_rst_n,
    input  logic                    i_push,
    input  logic [c_DATA_WIDTH-1:0] i_data,
    input  logic                    i_pop,
    output logic [c_DATA_WIDTH-1:0] o_data,
    output logic [c_SKID_CNT_W-1:0] o_count
);

    logic [c_DATA_WIDTH-1:0] r_mem [c_SKID_DEPTH];
    logic                    r_wr_ptr;
    logic                    r_rd_ptr;
    logic [c_SKID_CNT_W-1:0] r_count;

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            for (int i = 0; i < c_SKID_DEPTH; i++) begin
                r_mem[i] <= '0;
            end
            r_wr_ptr <= 1'b0;
            r_rd_ptr <= 1'b0;
            r_count  <= '0;
        end else begin
            if (i_push) begin
                r_mem[r_wr_ptr] <= i_data;
                r_wr_ptr        <= ~r_wr_ptr;
            end
            if (i_pop) begin
                r_rd_ptr <= ~r_rd_ptr;
            end
            case ({i_push, i_pop})
                2'b10:   r_count <= r_count + 1'b1;
                2'b01:   r_count <= r_count - 1'b1;
                default: r_count <= r_count;
            endcase
        end
    end

    assign o_data  = r_mem[r_rd_ptr];
    assign o_count = r_count;

endmodule

// File: rtl/udp_fifo_pkt_reader.sv
// Frames bytes buffered in the RX/TX FIFO into UDP packets: announces each
// packet to the transmitter, then drains exactly that many bytes as a stream.
//
// state    | meaning
// ST_IDLE  | watch water level, run flush timer, decide packet length
// ST_ANNOUNCE | one-cycle tx_start with tx_byte_num
// ST_STREAM   | read FIFO through skid buffer, hand bytes downstream
// ST_SETTLE   | two idle cycles so the registered level catches up
module udp_fifo_pkt_reader
    import udp_fifo_pkg::*;
#(
    parameter int c_RD_DEPTH_WIDTH = 11,
    parameter int c_DATA_WIDTH     = 8,
    parameter int c_MAX_PKT_LEN    = 1472,
    parameter int c_FLUSH_TIMEOUT  = 1024
)
(
    input  logic                      i_rclk,
    input  logic                      i_rrst_n,
    input  logic                      i_fifo_rempty,
    input  logic [c_RD_DEPTH_WIDTH:0] i_fifo_rd_level,
    input  logic [c_DATA_WIDTH-1:0]   i_fifo_rdata,
    output logic                      o_fifo_r_en,
    input  logic                      i_tx_busy,
    output logic                      o_tx_start,
    output logic [c_LEN_WIDTH-1:0]    o_tx_byte_num,
    output logic [c_DATA_WIDTH-1:0]   o_m_data,
    output logic                      o_m_valid,
    input  logic                      i_m_ready,
    output logic                      o_m_last,
    output logic                      o_pkt_done
);

    localparam int                      c_TMR_W   = $clog2(c_FLUSH_TIMEOUT + 1);
    localparam logic [c_TMR_W-1:0]      c_TMR_MAX = c_TMR_W'(c_FLUSH_TIMEOUT);
    localparam len_t                    c_MAX_LEN = len_t'(c_MAX_PKT_LEN);
    localparam logic [c_SKID_CNT_W:0]   c_OCC_LIM = (c_SKID_CNT_W + 1)'(c_SKID_DEPTH);

    rd_state_t              r_state;
    rd_state_t              w_state_nxt;
    logic [c_TMR_W-1:0]     r_timer;
    len_t                   r_len;
    len_t                   r_rd_left;
    len_t                   r_out_cnt;
    logic                   r_rd_pend;
    logic                   r_pkt_done;
    logic                   r_settle;

    len_t                   w_level;
    logic                   w_level_zero;
    logic                   w_level_full;
    logic                   w_go_full;
    logic                   w_go_flush;
    logic                   w_pop;
    logic                   w_last_hs;
    logic                   w_fifo_r_en;
    logic [c_SKID_CNT_W-1:0] w_skid_cnt;
    logic [c_SKID_CNT_W:0]  w_occ;

    assign w_level      = len_t'(i_fifo_rd_level);
    assign w_level_zero = (w_level == '0);
    assign w_level_full = (w_level >= c_MAX_LEN);

    udp_fifo_skid2 #(
        .c_DATA_WIDTH (c_DATA_WIDTH)
    ) u_skid (
        .i_clk   (i_rclk),
        .i_rst_n (i_rrst_n),
        .i_push  (r_rd_pend),
        .i_data  (i_fifo_rdata),
        .i_pop   (w_pop),
        .o_data  (o_m_data),
        .o_count (w_skid_cnt)
    );

    assign o_m_valid = (w_skid_cnt != '0);
    assign w_pop     = o_m_valid & i_m_ready;
    assign o_m_last  = o_m_valid && (r_out_cnt == (r_len - 1'b1));
    assign w_last_hs = w_pop & o_m_last;

    // Credit the byte leaving this cycle so reads continue back-to-back.
    assign w_occ = (c_SKID_CNT_W + 1)'(w_skid_cnt) + (c_SKID_CNT_W + 1)'(r_rd_pend)
                 - (c_SKID_CNT_W + 1)'(w_pop);

    assign w_fifo_r_en = (r_state == ST_STREAM) && (r_rd_left != '0) &&
                         !i_fifo_rempty && (w_occ < c_OCC_LIM);

    assign o_fifo_r_en   = w_fifo_r_en;
    assign o_tx_start    = (r_state == ST_ANNOUNCE);
    assign o_tx_byte_num = r_len;
    assign o_pkt_done    = r_pkt_done;

    always_comb begin
        w_state_nxt = r_state;
        w_go_full   = 1'b0;
        w_go_flush  = 1'b0;
        case (r_state)
            ST_IDLE: begin
                if (!i_tx_busy) begin
                    if (w_level_full) begin
                        w_go_full   = 1'b1;
                        w_state_nxt = ST_ANNOUNCE;
                    end else if ((r_timer == c_TMR_MAX) && !w_level_zero) begin
                        w_go_flush  = 1'b1;
                        w_state_nxt = ST_ANNOUNCE;
                    end
                end
            end
            ST_ANNOUNCE: w_state_nxt = ST_STREAM;
            ST_STREAM: begin
                if (w_last_hs) begin
                    w_state_nxt = ST_SETTLE;
                end
            end
            ST_SETTLE: begin
                if (r_settle) begin
                    w_state_nxt = ST_IDLE;
                end
            end
            default: w_state_nxt = ST_IDLE;
        endcase
    end

    always_ff @(posedge i_rclk or negedge i_rrst_n) begin
        if (!i_rrst_n) begin
            r_state    <= ST_IDLE;
            r_timer    <= '0;
            r_len      <= '0;
            r_rd_left  <= '0;
            r_out_cnt  <= '0;
            r_rd_pend  <= 1'b0;
            r_pkt_done <= 1'b0;
            r_settle   <= 1'b0;
        end else begin
            r_state    <= w_state_nxt;
            r_rd_pend  <= w_fifo_r_en;
            r_pkt_done <= w_last_hs;

            // Flush timer only ages a partial fill while idle; saturates.
            if ((r_state == ST_IDLE) && !w_level_zero && !w_level_full) begin
                if (r_timer != c_TMR_MAX) begin
                    r_timer <= r_timer + 1'b1;
                end
            end else begin
                r_timer <= '0;
            end

            if (w_go_full) begin
                r_len     <= c_MAX_LEN;
                r_rd_left <= c_MAX_LEN;
            end else if (w_go_flush) begin
                r_len     <= w_level;
                r_rd_left <= w_level;
            end else if (w_fifo_r_en) begin
                r_rd_left <= r_rd_left - 1'b1;
            end

            if (r_state == ST_ANNOUNCE) begin
                r_out_cnt <= '0;
            end else if (w_pop) begin
                r_out_cnt <= r_out_cnt + 1'b1;
            end

            if (r_state == ST_SETTLE) begin
                r_settle <= ~r_settle;
            end else begin
                r_settle <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_udp_fifo_pkt_reader.sv
// Bench for udp_fifo_pkt_reader: behavioural FIFO feeding sequential bytes,
// stream monitor, packet-scenario table plus reset/busy sequences.
module tb_udp_fifo_pkt_reader;

    localparam int DEPTH = 2048;

    logic        rclk = 1'b0;
    logic        rrst_n = 1'b0;
    logic        rempty, r_en, tx_busy, tx_start, m_valid, m_ready, m_last, pkt_done;
    logic [11:0] level;
    logic [7:0]  rdata, m_data;
    logic [15:0] tx_byte_num;
    logic        jam;

    always #5 rclk = ~rclk;

    udp_fifo_pkt_reader dut (
        .i_rclk          (rclk),
        .i_rrst_n        (rrst_n),
        .i_fifo_rempty   (rempty),
        .i_fifo_rd_level (level),
        .i_fifo_rdata    (rdata),
        .o_fifo_r_en     (r_en),
        .i_tx_busy       (tx_busy),
        .o_tx_start      (tx_start),
        .o_tx_byte_num   (tx_byte_num),
        .o_m_data        (m_data),
        .o_m_valid       (m_valid),
        .i_m_ready       (m_ready),
        .o_m_last        (m_last),
        .o_pkt_done      (pkt_done)
    );

    // FIFO model: byte n written is 8'(n); a backlog refills as space frees.
    int req_total = 0;
    int f_cnt = 0, f_written = 0, f_rdseq = 0, f_nwr, f_space;

    always_comb begin
        f_space = DEPTH - f_cnt + (r_en ? 1 : 0);
        f_nwr   = req_total - f_written;
        if (f_nwr > f_space) f_nwr = f_space;
    end

    always @(posedge rclk or negedge rrst_n) begin
        if (!rrst_n) begin
            f_cnt     <= 0;
            f_written <= req_total;
            f_rdseq   <= req_total;
            rdata     <= 8'd0;
        end else begin
            f_written <= f_written + f_nwr;
            f_cnt     <= f_cnt + f_nwr - (r_en ? 1 : 0);
            if (r_en) begin
                rdata   <= 8'(f_rdseq);
                f_rdseq <= f_rdseq + 1;
            end
        end
    end

    assign level  = 12'(f_cnt);
    assign rempty = (f_cnt == 0) || jam;

    // Stream monitor
    int   cyc = 0;
    int   mon_hs = 0, mon_last = 0, mon_done = 0, mon_ren = 0, mon_start = 0;
    int   data_err = 0, last_err = 0, stall_err = 0, empty_err = 0;
    int   e_seq = 0, cur_len = 0, out_idx = 0, fv_cyc = 0, lh_cyc = 0;
    bit   fv_seen = 1'b0, prev_stall = 1'b0;
    logic [7:0] prev_data = 8'd0;
    logic prev_last = 1'b0;
    int   len_q[$];
    int   start_cyc_q[$];

    always @(posedge rclk) cyc <= cyc + 1;

    always @(negedge rclk) begin
        if (!rrst_n) begin
            e_seq      <= req_total;
            out_idx    <= 0;
            prev_stall <= 1'b0;
        end else begin
            if (r_en) mon_ren <= mon_ren + 1;
            if (r_en && rempty) empty_err <= empty_err + 1;
            if (pkt_done) mon_done <= mon_done + 1;
            if (prev_stall && (!m_valid || m_data != prev_data || m_last != prev_last))
                stall_err <= stall_err + 1;
            prev_stall <= m_valid && !m_ready;
            prev_data  <= m_data;
            prev_last  <= m_last;
            if (m_last != (m_valid && (out_idx == cur_len - 1))) last_err <= last_err + 1;
            if (m_valid && m_ready) begin
                mon_hs  <= mon_hs + 1;
                e_seq   <= e_seq + 1;
                out_idx <= out_idx + 1;
                if (m_data != 8'(e_seq)) data_err <= data_err + 1;
                if (m_last) begin
                    mon_last <= mon_last + 1;
                    lh_cyc   <= cyc;
                end
            end
            if (tx_start) begin
                mon_start <= mon_start + 1;
                len_q.push_back(int'(tx_byte_num));
                start_cyc_q.push_back(cyc);
                cur_len <= int'(tx_byte_num);
                out_idx <= 0;
                fv_seen <= 1'b0;
            end else if (m_valid && !fv_seen) begin
                fv_seen <= 1'b1;
                fv_cyc  <= cyc;
            end
        end
    end

    // Checking
    int total = 0, bad = 0;
    int s_hs, s_last, s_done, s_ren, s_start, s_q, s_cyc, s_de, s_le, s_se, s_ee;

    task automatic chk(input string name, input int act, input int exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0d, want %0d", name, act, exp);
        end
    endtask

    task automatic step(input int rdy_pct, input int jam_pct);
        @(posedge rclk);
        #1;
        m_ready = (int'($urandom_range(99)) < rdy_pct);
        jam     = (int'($urandom_range(99)) < jam_pct);
    endtask

    task automatic snap();
        s_hs = mon_hs; s_last = mon_last; s_done = mon_done; s_ren = mon_ren;
        s_start = mon_start; s_q = len_q.size(); s_cyc = cyc;
        s_de = data_err; s_le = last_err; s_se = stall_err; s_ee = empty_err;
    endtask

    function automatic int outs_word();
        return int'({tx_start, r_en, m_valid, m_last, pkt_done, tx_byte_num});
    endfunction

    function automatic int q_len(input int idx);
        return (len_q.size() > idx) ? len_q[idx] : -1;
    endfunction

    typedef struct {
        int nbytes;
        int rdy_pct;
        int jam_pct;
        int npkt;
        int len0;
        int len1;
        int len2;
        int min_wait;
        int chk_rate;
    } vec_t;

    vec_t vecs[5];
    vec_t v;
    int   el[3];
    int   esum, wdelta;

    initial begin
        m_ready = 1'b0;
        tx_busy = 1'b0;
        jam     = 1'b0;

        vecs[0] = '{1472, 100,  0, 1, 1472,    0,  0,    0, 1};  // exactly MAX
        vecs[1] = '{ 100, 100,  0, 1,  100,    0,  0, 1024, 0};  // short after timeout
        vecs[2] = '{   1, 100,  0, 1,    1,    0,  0, 1024, 0};  // len 1
        vecs[3] = '{1473, 100,  0, 2, 1472,    1,  0,    0, 0};  // MAX then 1
        vecs[4] = '{3000,  50, 20, 3, 1472, 1472, 56,    0, 0};  // backpressure + empty gaps

        // Reset with level 0
        repeat (3) @(posedge rclk);
        #1;
        chk("rst_outs_low", outs_word(), 0);
        rrst_n = 1'b1;
        step(100, 0);
        chk("rst_outs_after", outs_word(), 0);
        repeat (5000) step(100, 0);
        chk("idle_no_start", mon_start, 0);
        chk("idle_no_read", mon_ren, 0);

        for (int i = 0; i < 5; i++) begin
            v = vecs[i];
            el[0] = v.len0; el[1] = v.len1; el[2] = v.len2;
            esum = v.len0 + v.len1 + v.len2;
            snap();
            req_total = req_total + v.nbytes;
            for (int c = 0; c < 40000 && (mon_done - s_done) < v.npkt; c++) step(v.rdy_pct, v.jam_pct);
            repeat (10) step(100, 0);
            chk($sformatf("v%0d_starts", i), mon_start - s_start, v.npkt);
            chk($sformatf("v%0d_done", i), mon_done - s_done, v.npkt);
            for (int p = 0; p < v.npkt; p++)
                chk($sformatf("v%0d_len%0d", i, p), q_len(s_q + p), el[p]);
            chk($sformatf("v%0d_bytes", i), mon_hs - s_hs, esum);
            chk($sformatf("v%0d_reads", i), mon_ren - s_ren, esum);
            chk($sformatf("v%0d_lasts", i), mon_last - s_last, v.npkt);
            chk($sformatf("v%0d_data_err", i), data_err - s_de, 0);
            chk($sformatf("v%0d_last_err", i), last_err - s_le, 0);
            chk($sformatf("v%0d_stall_err", i), stall_err - s_se, 0);
            chk($sformatf("v%0d_empty_rd", i), empty_err - s_ee, 0);
            if (v.min_wait > 0) begin
                wdelta = (start_cyc_q.size() > s_q) ? start_cyc_q[s_q] - s_cyc : -1;
                chk($sformatf("v%0d_flush_wait_ok", i),
                    (wdelta >= v.min_wait && wdelta <= v.min_wait + 8) ? 1 : 0, 1);
            end
            if (v.chk_rate != 0)
                chk($sformatf("v%0d_no_bubble", i), lh_cyc - fv_cyc, v.len0 - 1);
        end

        // tx_busy gates the full-packet decision, but not an active stream
        snap();
        tx_busy = 1'b1;
        req_total = req_total + 1472;
        repeat (200) step(100, 0);
        chk("busy_hold", mon_start - s_start, 0);
        tx_busy = 1'b0;
        for (int c = 0; c < 20 && mon_start == s_start; c++) step(100, 0);
        chk("busy_release_start", mon_start - s_start, 1);
        chk("busy_len", q_len(s_q), 1472);
        tx_busy = 1'b1;
        for (int c = 0; c < 5000 && mon_done == s_done; c++) step(100, 0);
        chk("busy_stream_done", mon_done - s_done, 1);
        chk("busy_bytes", mon_hs - s_hs, 1472);
        chk("busy_data_err", data_err - s_de, 0);
        tx_busy = 1'b0;
        repeat (10) step(100, 0);

        // Reset in the middle of a packet
        snap();
        req_total = req_total + 1472;
        for (int c = 0; c < 5000 && (mon_hs - s_hs) < 700; c++) step(100, 0);
        chk("mid_reach_700", mon_hs - s_hs, 700);
        #2 rrst_n = 1'b0;
        #1;
        chk("mid_rst_outs", outs_word(), 0);
        repeat (3) @(posedge rclk);
        #1 rrst_n = 1'b1;
        repeat (2000) step(100, 0);
        chk("mid_no_last", mon_last - s_last, 0);
        chk("mid_no_done", mon_done - s_done, 0);
        chk("mid_no_restart", mon_start - s_start, 1);
        snap();
        req_total = req_total + 5;
        for (int c = 0; c < 3000 && mon_done == s_done; c++) step(100, 0);
        chk("post_rst_len", q_len(s_q), 5);
        chk("post_rst_bytes", mon_hs - s_hs, 5);
        chk("post_rst_last", mon_last - s_last, 1);
        chk("post_rst_data_err", data_err - s_de, 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
